// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the multi-port register file.
//   dbg_state_t : debug access state machine encoding (IDLE, ACCESS, DONE)
//   DEF_*       : default configuration constants used by the top, interface and sub-module
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_REG_COUNT   = 32;
  localparam int unsigned DEF_READ_PORTS  = 2;
  localparam int unsigned DEF_WRITE_PORTS = 2;
  localparam bit          DEF_ZERO_REG    = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dbg_state_t;

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle between the core/debug unit (master) and the register file (slave).
//   master : drives write ports, read addresses and debug requests; receives read data,
//            debug response and live register contents
//   slave  : the register file side of the same signals
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned REG_COUNT   = DEF_REG_COUNT,
  parameter int unsigned ADDR_WIDTH  = $clog2(REG_COUNT),
  parameter int unsigned READ_PORTS  = DEF_READ_PORTS,
  parameter int unsigned WRITE_PORTS = DEF_WRITE_PORTS
);

  logic [WRITE_PORTS-1:0]                 writeEnable;
  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] writeAddress;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] writeData;
  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  readAddress;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  readData;
  logic                                   debugReq;
  logic                                   debugWrite;
  logic [ADDR_WIDTH-1:0]                  debugAddress;
  logic [DATA_WIDTH-1:0]                  debugWriteData;
  logic                                   debugAck;
  logic [DATA_WIDTH-1:0]                  debugReadData;
  logic                                   debugBusy;
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]   regfileState;

  modport master (
    output writeEnable, writeAddress, writeData, readAddress,
    output debugReq, debugWrite, debugAddress, debugWriteData,
    input  readData, debugAck, debugReadData, debugBusy, regfileState
  );

  modport slave (
    input  writeEnable, writeAddress, writeData, readAddress,
    input  debugReq, debugWrite, debugAddress, debugWriteData,
    output readData, debugAck, debugReadData, debugBusy, regfileState
  );

endinterface

// File: rtl/regfile_debug_ctrl.sv
// Debug access controller: sequences one debug read or write through IDLE -> ACCESS -> DONE.
// A debug write waits in ACCESS while any CPU write port is active, so the CPU always wins.
//   clk, reset  : clock, synchronous active-high reset (aborts any transaction)
//   req         : debug request, held until ack
//   write_op    : 1 = write, 0 = read
//   cpu_wr_any  : some CPU write port is enabled this cycle
//   rd_value    : current (pre-write) content of the addressed register
//   ack         : registered one-cycle completion pulse
//   busy        : registered, request accepted and not yet acknowledged
//   rd_data     : registered read result, valid with ack
//   wr_en_c     : combinational, commit debug write data this cycle
module regfile_debug_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  write_op,
  input  logic                  cpu_wr_any,
  input  logic [DATA_WIDTH-1:0] rd_value,
  output logic                  ack,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en_c
);

  dbg_state_t state, state_next;
  logic       ack_next, busy_next, capture_c;

  // State register plus the registered outputs it drives
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ack     <= 1'b0;
      busy    <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_next;
      ack   <= ack_next;
      busy  <= busy_next;
      if (capture_c) rd_data <= rd_value;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = ACCESS;
      ACCESS:  if (!write_op || !cpu_wr_any) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; ack/busy are next values for the output registers
  always_comb begin
    ack_next  = 1'b0;
    busy_next = 1'b0;
    capture_c = 1'b0;
    wr_en_c   = 1'b0;
    case (state)
      IDLE:   busy_next = req;
      ACCESS: begin
        busy_next = 1'b1;
        capture_c = !write_op;
        wr_en_c   = write_op && !cpu_wr_any;
      end
      DONE:    ack_next = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with write-port priority, optional zero register
// and a handshaked debug access port.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears all registers and outputs
//   bus   : regfile_multiport_if slave port (write/read ports, debug port, live state)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to read ports.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned REG_COUNT   = DEF_REG_COUNT,
  parameter int unsigned ADDR_WIDTH  = $clog2(REG_COUNT),
  parameter int unsigned READ_PORTS  = DEF_READ_PORTS,
  parameter int unsigned WRITE_PORTS = DEF_WRITE_PORTS,
  parameter bit          ZERO_REG    = DEF_ZERO_REG
) (
  input logic                clk,
  input logic                reset,
  regfile_multiport_if.slave bus
);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  regs, regs_next;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rd_next;
  logic [DATA_WIDTH-1:0]                 dbg_rd_value_c;
  logic                                  cpu_wr_any_c;
  logic                                  dbg_wr_en_c;

  assign cpu_wr_any_c     = |bus.writeEnable;
  assign bus.regfileState = regs;

  // Write resolution: scan ports high to low so the lowest-index match lands last.
  // Debug writes only commit when no CPU port is active, so they never collide.
  always_comb begin
    regs_next = regs;
    for (int r = 0; r < int'(REG_COUNT); r++) begin
      if (dbg_wr_en_c && (bus.debugAddress == ADDR_WIDTH'(r)))
        regs_next[r] = bus.debugWriteData;
      for (int p = int'(WRITE_PORTS) - 1; p >= 0; p--) begin
        if (bus.writeEnable[p] && (bus.writeAddress[p] == ADDR_WIDTH'(r)))
          regs_next[r] = bus.writeData[p];
      end
    end
    if (ZERO_REG) regs_next[0] = '0;
  end

  // Register storage
  always_ff @(posedge clk) begin
    if (reset) regs <= '0;
    else       regs <= regs_next;
  end

  // Read ports: out-of-range and hardwired-zero addresses read as 0
  always_comb begin
    for (int i = 0; i < int'(READ_PORTS); i++) begin
      rd_next[i] = '0;
      if ((32'(bus.readAddress[i]) < REG_COUNT) &&
          !(ZERO_REG && (bus.readAddress[i] == '0))) begin
        rd_next[i] = regs[bus.readAddress[i]];
`ifdef REGFILE_BYPASS_EN
        // Forward the priority-resolved same-cycle write data
        for (int p = int'(WRITE_PORTS) - 1; p >= 0; p--) begin
          if (bus.writeEnable[p] && (bus.writeAddress[p] == bus.readAddress[i]))
            rd_next[i] = bus.writeData[p];
        end
`endif
      end
    end
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (reset) bus.readData <= '0;
    else       bus.readData <= rd_next;
  end

  // Debug path sees stored contents only, never same-cycle write data
  always_comb begin
    dbg_rd_value_c = '0;
    if ((32'(bus.debugAddress) < REG_COUNT) && !(ZERO_REG && (bus.debugAddress == '0)))
      dbg_rd_value_c = regs[bus.debugAddress];
  end

  regfile_debug_ctrl #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_debug_ctrl (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.debugReq),
    .write_op   (bus.debugWrite),
    .cpu_wr_any (cpu_wr_any_c),
    .rd_value   (dbg_rd_value_c),
    .ack        (bus.debugAck),
    .busy       (bus.debugBusy),
    .rd_data    (bus.debugReadData),
    .wr_en_c    (dbg_wr_en_c)
  );

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport.
// Two instances: the default 32x32 2R/2W configuration, and a 10-entry 1R/1W one with the
// zero register enabled (also exercises out-of-range addresses).
module tb_regfile_multiport;
  import regfile_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_byp;

  regfile_multiport_if #(.DATA_WIDTH(32), .REG_COUNT(32), .READ_PORTS(2), .WRITE_PORTS(2)) m ();
  regfile_multiport_if #(.DATA_WIDTH(32), .REG_COUNT(10), .READ_PORTS(1), .WRITE_PORTS(1)) z ();

  regfile_multiport #(
    .DATA_WIDTH(32), .REG_COUNT(32), .READ_PORTS(2), .WRITE_PORTS(2), .ZERO_REG(1'b0)
  ) dut_main (
    .clk   (clk),
    .reset (reset),
    .bus   (m.slave)
  );

  regfile_multiport #(
    .DATA_WIDTH(32), .REG_COUNT(10), .READ_PORTS(1), .WRITE_PORTS(1), .ZERO_REG(1'b1)
  ) dut_zero (
    .clk   (clk),
    .reset (reset),
    .bus   (z.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset            = 1'b1;
    m.writeEnable    = '0;
    m.writeAddress   = '0;
    m.writeData      = '0;
    m.readAddress    = '0;
    m.debugReq       = 1'b0;
    m.debugWrite     = 1'b0;
    m.debugAddress   = '0;
    m.debugWriteData = '0;
    z.writeEnable    = '0;
    z.writeAddress   = '0;
    z.writeData      = '0;
    z.readAddress    = '0;
    z.debugReq       = 1'b0;
    z.debugWrite     = 1'b0;
    z.debugAddress   = '0;
    z.debugWriteData = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state: every address reads 0 on both ports, debug outputs idle
    check("rst_ack", 32'(m.debugAck), 32'd0);
    check("rst_busy", 32'(m.debugBusy), 32'd0);
    check("rst_dbg_rdata", m.debugReadData, 32'd0);
    for (int a = 0; a < 32; a++) begin
      m.readAddress[0] = 5'(a);
      m.readAddress[1] = 5'(31 - a);
      tick();
      check("rst_rd0", m.readData[0], 32'd0);
      check("rst_rd1", m.readData[1], 32'd0);
    end

    // Same-address conflict: port 0 wins
    m.writeEnable     = 2'b11;
    m.writeAddress[0] = 5'd5;
    m.writeData[0]    = 32'hAAAA_0000;
    m.writeAddress[1] = 5'd5;
    m.writeData[1]    = 32'h5555_FFFF;
    tick();
    check("prio_reg5", m.regfileState[5], 32'hAAAA_0000);

    // Non-conflicting ports both write
    m.writeAddress[0] = 5'd3;
    m.writeData[0]    = 32'h3333_3333;
    m.writeAddress[1] = 5'd7;
    m.writeData[1]    = 32'h7777_7777;
    tick();
    m.writeEnable = 2'b00;
    check("dual_reg3", m.regfileState[3], 32'h3333_3333);
    check("dual_reg7", m.regfileState[7], 32'h7777_7777);
    check("dual_reg5_kept", m.regfileState[5], 32'hAAAA_0000);

    // Registered read of written values
    m.readAddress[0] = 5'd5;
    m.readAddress[1] = 5'd7;
    tick();
    check("rd_reg5", m.readData[0], 32'hAAAA_0000);
    check("rd_reg7", m.readData[1], 32'h7777_7777);

    // Same-cycle read/write of address 9, conflicting ports
    m.writeEnable     = 2'b01;
    m.writeAddress[0] = 5'd9;
    m.writeData[0]    = 32'h1111_1111;
    tick();
    m.writeEnable     = 2'b11;
    m.writeAddress[0] = 5'd9;
    m.writeData[0]    = 32'h1234_5678;
    m.writeAddress[1] = 5'd9;
    m.writeData[1]    = 32'hFFFF_FFFF;
    m.readAddress[0]  = 5'd9;
    tick();
    m.writeEnable = 2'b00;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h1234_5678;
`else
    exp_byp = 32'h1111_1111;
`endif
    check("same_cycle_rd9", m.readData[0], exp_byp);
    check("same_cycle_reg9", m.regfileState[9], 32'h1234_5678);
    tick();
    check("next_cycle_rd9", m.readData[0], 32'h1234_5678);

    // Debug write to 12 stalled by CPU writes to 20 for three ACCESS cycles
    m.debugReq        = 1'b1;
    m.debugWrite      = 1'b1;
    m.debugAddress    = 5'd12;
    m.debugWriteData  = 32'hCAFE_F00D;
    m.writeEnable     = 2'b01;
    m.writeAddress[0] = 5'd20;
    m.writeData[0]    = 32'h0000_0020;
    tick();
    check("dw_accept_busy", 32'(m.debugBusy), 32'd1);
    check("dw_accept_ack", 32'(m.debugAck), 32'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("dw_stall_busy", 32'(m.debugBusy), 32'd1);
      check("dw_stall_ack", 32'(m.debugAck), 32'd0);
      check("dw_stall_reg12", m.regfileState[12], 32'd0);
    end
    m.writeEnable = 2'b00;
    tick();
    check("dw_commit_reg12", m.regfileState[12], 32'hCAFE_F00D);
    check("dw_commit_ack", 32'(m.debugAck), 32'd0);
    check("dw_commit_busy", 32'(m.debugBusy), 32'd1);
    check("dw_cpu_reg20", m.regfileState[20], 32'h0000_0020);
    tick();
    check("dw_ack", 32'(m.debugAck), 32'd1);
    check("dw_ack_busy", 32'(m.debugBusy), 32'd0);
    m.debugReq = 1'b0;
    tick();
    check("dw_ack_pulse", 32'(m.debugAck), 32'd0);
    check("dw_idle_busy", 32'(m.debugBusy), 32'd0);

    // Debug read of 12 with a CPU write to 12 in the ACCESS cycle: old value returned
    m.debugReq     = 1'b1;
    m.debugWrite   = 1'b0;
    m.debugAddress = 5'd12;
    tick();
    check("dr_busy", 32'(m.debugBusy), 32'd1);
    m.writeEnable     = 2'b01;
    m.writeAddress[0] = 5'd12;
    m.writeData[0]    = 32'hBBBB_BBBB;
    tick();
    m.writeEnable = 2'b00;
    check("dr_no_early_ack", 32'(m.debugAck), 32'd0);
    tick();
    check("dr_ack", 32'(m.debugAck), 32'd1);
    check("dr_data", m.debugReadData, 32'hCAFE_F00D);
    check("dr_cpu_reg12", m.regfileState[12], 32'hBBBB_BBBB);
    m.debugReq = 1'b0;
    tick();

    // Reset while a debug write is stalled in ACCESS
    m.debugReq        = 1'b1;
    m.debugWrite      = 1'b1;
    m.debugAddress    = 5'd14;
    m.debugWriteData  = 32'h1414_1414;
    m.writeEnable     = 2'b01;
    m.writeAddress[0] = 5'd20;
    m.writeData[0]    = 32'h0000_0099;
    tick();
    tick();
    check("rstmid_busy_before", 32'(m.debugBusy), 32'd1);
    reset         = 1'b1;
    m.debugReq    = 1'b0;
    m.writeEnable = 2'b00;
    tick();
    reset = 1'b0;
    check("rstmid_busy", 32'(m.debugBusy), 32'd0);
    check("rstmid_ack", 32'(m.debugAck), 32'd0);
    check("rstmid_reg20", m.regfileState[20], 32'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("rstmid_no_ack", 32'(m.debugAck), 32'd0);
      check("rstmid_reg14", m.regfileState[14], 32'd0);
      check("rstmid_idle_busy", 32'(m.debugBusy), 32'd0);
    end

    // Zero register: writes to 0 dropped, reads of 0 return 0 (same cycle too)
    z.writeEnable     = 1'b1;
    z.writeAddress[0] = 4'd0;
    z.writeData[0]    = 32'hDEAD_BEEF;
    z.readAddress[0]  = 4'd0;
    tick();
    check("zero_state0", z.regfileState[0], 32'd0);
    check("zero_rd0_same", z.readData[0], 32'd0);
    z.writeAddress[0] = 4'd3;
    z.writeData[0]    = 32'h0000_0003;
    tick();
    z.writeEnable = 1'b0;
    check("zero_rd0", z.readData[0], 32'd0);
    check("zero_reg3", z.regfileState[3], 32'h0000_0003);
    z.readAddress[0] = 4'd3;
    tick();
    check("zero_rd3", z.readData[0], 32'h0000_0003);

    // Out-of-range address 12 on a 10-entry file: write ignored, read returns 0
    z.writeEnable     = 1'b1;
    z.writeAddress[0] = 4'd12;
    z.writeData[0]    = 32'h1234_5678;
    z.readAddress[0]  = 4'd12;
    tick();
    z.writeEnable = 1'b0;
    check("oor_rd_same", z.readData[0], 32'd0);
    check("oor_reg2", z.regfileState[2], 32'd0);
    check("oor_reg4", z.regfileState[4], 32'd0);
    check("oor_reg3", z.regfileState[3], 32'h0000_0003);
    tick();
    check("oor_rd", z.readData[0], 32'd0);

    // Debug write to the zero register completes but is dropped
    z.debugReq       = 1'b1;
    z.debugWrite     = 1'b1;
    z.debugAddress   = 4'd0;
    z.debugWriteData = 32'hFFFF_FFFF;
    tick();
    tick();
    check("zdbg_no_early_ack", 32'(z.debugAck), 32'd0);
    tick();
    check("zdbg_ack", 32'(z.debugAck), 32'd1);
    check("zdbg_state0", z.regfileState[0], 32'd0);
    z.debugReq = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-port CPU register file; successor to the fixed 32x32, 2-write/2-read register file in the cpu32e2 core. Adds configurable width, depth and port counts, a deterministic write-priority rule for any number of write ports, an optional hardwired zero register, and a handshaked debug access port serviced by a small state machine. It sits between the decode/writeback stages and the core's debug unit.

## Interface
- DATA_WIDTH, 32: register width in bits
- REG_COUNT, 32: number of registers; must be ≥2
- ADDR_WIDTH, $clog2(REG_COUNT): register address width
- READ_PORTS, 2: number of read ports; must be ≥1
- WRITE_PORTS, 2: number of write ports; must be ≥1
- ZERO_REG, 0: 1 makes register 0 read as zero and ignore writes

- clk  in  1  core clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- writeEnable  in  [WRITE_PORTS]  per-port write strobe
- writeAddress  in  [WRITE_PORTS][ADDR_WIDTH]  per-port write address
- writeData  in  [WRITE_PORTS][DATA_WIDTH]  per-port write data
- readAddress  in  [READ_PORTS][ADDR_WIDTH]  per-port read address
- readData  out  [READ_PORTS][DATA_WIDTH]  registered read data
- debugReq  in  1  debug access request; held until debugAck
- debugWrite  in  1  1 = write, 0 = read; stable while debugReq high
- debugAddress  in  ADDR_WIDTH  debug register address
- debugWriteData  in  DATA_WIDTH  debug write data
- debugAck  out  1  one-cycle completion pulse
- debugReadData  out  DATA_WIDTH  debug read result, valid with debugAck
- debugBusy  out  1  debug request accepted, not yet acknowledged
- regfileState  out  [REG_COUNT][DATA_WIDTH]  live register contents

## Operation
- Write resolution per cycle: for each register, the lowest-index port with writeEnable set and matching address wins; higher-index same-address writes are discarded. Non-conflicting ports all write.
- ZERO_REG=1: writes to address 0 dropped (including debug); register 0, regfileState[0] and any read of address 0 return 0.
- Out-of-range addresses (≥REG_COUNT) on writes are ignored; reads return 0.
- Debug FSM states: IDLE, ACCESS, DONE.
  - IDLE: debugReq=1 → ACCESS, debugBusy=1.
  - ACCESS, read: capture register into debugReadData → DONE.
  - ACCESS, write: if any writeEnable set this cycle, stay in ACCESS (CPU always wins); else write debugWriteData → DONE.
  - DONE: debugAck=1 for one cycle, debugBusy=0 → IDLE. A debugReq still high re-triggers from IDLE the following cycle.
- Debug read returns contents before any same-cycle CPU write (no bypass on debug path).

## Timing
- Reset: all registers 0; readData all 0; debugReadData 0; debugAck 0; debugBusy 0; FSM IDLE. Reset mid-debug aborts the transaction with no ack and no write.
- Read latency 1 cycle: readAddress at edge N → readData after edge N+1.
- Write visible in regfileState after the write edge.
- Debug read: request → debugAck 2 cycles after debugReq seen in IDLE. Debug write: ≥2 cycles, plus one per stalled ACCESS cycle; unbounded if CPU writes every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches an enabled write in the same cycle returns the priority-resolved new data (zero-register rule still applies).
- Undefined: same-cycle read returns old data; no bypass muxes are generated.

## Structure
- Package regfile_pkg: debug FSM state enum typedef (IDLE, ACCESS, DONE) and default parameter constants.
- Sub-module regfile_debug_ctrl: debug FSM, stall decision and ack/busy generation; storage, write resolution and read ports stay in the top module.

## Test plan
- Reset then read all addresses → readData 0 on every port; debugAck 0, debugBusy 0.
- Port 0 and port 1 both write address 5 (0xAAAA_0000, 0x5555_FFFF) → register 5 = 0xAAAA_0000; separate addresses 3/7 both written.
- ZERO_REG=1, write 0xDEAD_BEEF to address 0 → read of address 0 returns 0; regfileState[0] = 0.
- Read address 9 same cycle as write 0x1234_5678 to 9 → with REGFILE_BYPASS_EN, readData 0x1234_5678; without, prior value.
- Debug write 0xCAFE_F00D to address 12 while writeEnable is high for 3 cycles → FSM holds in ACCESS 3 cycles, then write, debugAck after 5 cycles total; debug read of 12 returns 0xCAFE_F00D.
- Assert reset while FSM is in ACCESS for a debug write → no debugAck, register unchanged, FSM IDLE.
